gpio_pattern_gen: RTL and testbench

//  Parametrised GPIO pattern generator that drives a WIDTH-bit pattern onto the board GPIO banks.
//  - A programmable prescaler paces pattern steps.
//  - Modes: rotate-left, rotate-right, ping-pong (bounce) and hold.
//  - Run-time pattern load; strobe and wrap outputs for the monitoring logic.
//  - Runs in the PCIe 125 MHz system clock domain.

---
 rtl/gpio_pattern_gen.sv | 178 +++++++++++++++++
 tb/tb_gpio_pattern_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pattern_gen.sv
// ---------------------------------------------------------------------------
// gpio_pattern_gen
//
// Purpose:
//   Drives a WIDTH-bit pattern onto the board GPIO banks. A programmable
//   prescaler paces the pattern steps. Each step rotates left, rotates right,
//   bounces between the two ends (ping-pong), or holds the pattern. A new
//   pattern can be loaded at run time. step_strobe and wrap let the
//   monitoring logic follow the pattern.
//
// Ports:
//   clk           in   1      system clock (125 MHz PCIe domain)
//   rstn          in   1      async active-low reset
//   enable        in   1      1 = prescaler runs; 0 = prescaler and pending tick cleared
//   div           in   DIV_W  step period minus 1, in clk cycles
//   mode          in   2      00 rot-left, 01 rot-right, 10 ping-pong, 11 hold
//   load          in   1      1-cycle request: pattern <= load_pattern
//   load_pattern  in   WIDTH  value taken on load
//   pattern_out   out  WIDTH  current pattern (registered)
//   step_strobe   out  1      pulses in the first cycle a stepped pattern is visible
//   wrap          out  1      pulses with step_strobe at the end of a full cycle
//
// Ping-pong direction register:
//   state     | meaning
//   DIR_LEFT  | moving toward the msb; turns around when pos reaches WIDTH-1
//   DIR_RIGHT | moving toward bit 0; turns around (and wraps) when pos reaches 0
// ---------------------------------------------------------------------------
module gpio_pattern_gen #(
    parameter int               WIDTH = 32,
    parameter int               DIV_W = 24,
    parameter logic [WIDTH-1:0] INIT  = {{(WIDTH-1){1'b1}}, 1'b0}
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pattern,
    output logic [WIDTH-1:0] pattern_out,
    output logic             step_strobe,
    output logic             wrap
);

    localparam int POS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] MODE_ROT_L  = 2'b00;
    localparam logic [1:0] MODE_ROT_R  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [POS_W-1:0] POS_FIRST = '0;
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(WIDTH - 1);

    logic [DIV_W-1:0] cnt;
    logic             tick_q;
    logic [POS_W-1:0] pos;
    logic             dir;

    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_r;
    logic [POS_W-1:0] pos_inc;
    logic [POS_W-1:0] pos_dec;

    logic [WIDTH-1:0] nxt_pattern;
    logic [POS_W-1:0] nxt_pos;
    logic             nxt_dir;
    logic             nxt_wrap;

    // ------------------------------------------------------------------
    // Prescaler. The >= compare lets a shrinking div terminate the
    // current count on the next cycle instead of running through the
    // whole counter range. A load restarts the step period from zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else if (load || !enable) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else if (cnt >= div) begin
            cnt    <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt    <= cnt + DIV_W'(1);
            tick_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Step arithmetic. pos tracks how far the pattern has been rotated
    // since the last load/reset, modulo WIDTH (WIDTH need not be a power
    // of two, so the wrap points are explicit).
    // ------------------------------------------------------------------
    always_comb begin
        rot_l   = {pattern_out[WIDTH-2:0], pattern_out[WIDTH-1]};
        rot_r   = {pattern_out[0], pattern_out[WIDTH-1:1]};
        pos_inc = (pos == POS_LAST)  ? POS_FIRST : pos + POS_W'(1);
        pos_dec = (pos == POS_FIRST) ? POS_LAST  : pos - POS_W'(1);
    end

    always_comb begin
        nxt_pattern = pattern_out;
        nxt_pos     = pos;
        nxt_dir     = dir;
        nxt_wrap    = 1'b0;
        case (mode)
            MODE_ROT_L: begin
                nxt_pattern = rot_l;
                nxt_pos     = pos_inc;
                nxt_wrap    = (pos_inc == POS_FIRST);
            end
            MODE_ROT_R: begin
                nxt_pattern = rot_r;
                nxt_pos     = pos_dec;
                nxt_wrap    = (pos_dec == POS_FIRST);
            end
            MODE_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    nxt_pattern = rot_l;
                    nxt_pos     = pos_inc;
                    if (pos_inc == POS_LAST) begin
                        nxt_dir = DIR_RIGHT;
                    end
                end else begin
                    nxt_pattern = rot_r;
                    nxt_pos     = pos_dec;
                    // One full bounce period ends on the return to bit 0.
                    if (pos_dec == POS_FIRST) begin
                        nxt_dir  = DIR_LEFT;
                        nxt_wrap = 1'b1;
                    end
                end
            end
            MODE_HOLD: begin
                nxt_pattern = pattern_out;
            end
            default: begin
                nxt_pattern = pattern_out;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pattern register. A load takes priority and swallows any step that
    // falls on the same edge, so the loaded value is always seen for a
    // full period before the first step.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pattern_out <= INIT;
            pos         <= POS_FIRST;
            dir         <= DIR_LEFT;
            step_strobe <= 1'b0;
            wrap        <= 1'b0;
        end else if (load) begin
            pattern_out <= load_pattern;
            pos         <= POS_FIRST;
            dir         <= DIR_LEFT;
            step_strobe <= 1'b0;
            wrap        <= 1'b0;
        end else if (tick_q) begin
            pattern_out <= nxt_pattern;
            pos         <= nxt_pos;
            dir         <= nxt_dir;
            step_strobe <= 1'b1;
            wrap        <= nxt_wrap;
        end else begin
            step_strobe <= 1'b0;
            wrap        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_pattern_gen.sv
module tb_gpio_pattern_gen;

    logic        clk = 1'b0;
    logic        rstn;

    // 32-bit instance with default parameters
    logic        enable;
    logic [23:0] div;
    logic [1:0]  mode;
    logic        load;
    logic [31:0] load_pattern;
    logic [31:0] pattern_out;
    logic        step_strobe;
    logic        wrap;

    // 8-bit instance for the ping-pong sequence
    logic        enable_b;
    logic [7:0]  div_b;
    logic [1:0]  mode_b;
    logic        load_b;
    logic [7:0]  load_pattern_b;
    logic [7:0]  pattern_b;
    logic        strobe_b;
    logic        wrap_b;

    int total = 0;
    int bad   = 0;

    logic wrap_seen;
    logic strobe_seen;
    logic strobe_all;

    logic [7:0] pp_exp [0:15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

    always #5 clk = ~clk;

    gpio_pattern_gen dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .div          (div),
        .mode         (mode),
        .load         (load),
        .load_pattern (load_pattern),
        .pattern_out  (pattern_out),
        .step_strobe  (step_strobe),
        .wrap         (wrap)
    );

    gpio_pattern_gen #(.WIDTH(8), .DIV_W(8), .INIT(8'h01)) dut_b (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable_b),
        .div          (div_b),
        .mode         (mode_b),
        .load         (load_b),
        .load_pattern (load_pattern_b),
        .pattern_out  (pattern_b),
        .step_strobe  (strobe_b),
        .wrap         (wrap_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rstn           = 1'b0;
        enable         = 1'b0;
        div            = 24'd3;
        mode           = 2'b00;
        load           = 1'b0;
        load_pattern   = 32'h0;
        enable_b       = 1'b0;
        div_b          = 8'd1;
        mode_b         = 2'b10;
        load_b         = 1'b0;
        load_pattern_b = 8'h0;

        cyc(2);
        chk("reset_pattern", pattern_out, 32'hFFFF_FFFE);
        chk("reset_strobe", {31'b0, step_strobe}, 32'd0);
        chk("reset_wrap", {31'b0, wrap}, 32'd0);
        chk("reset_pattern_b", {24'b0, pattern_b}, 32'h01);

        // ---- rot-left, div=3: first strobe after edge 5, period 4
        rstn   = 1'b1;
        enable = 1'b1;
        cyc(4);
        chk("rl_no_strobe_edge4", {31'b0, step_strobe}, 32'd0);
        cyc(1);
        chk("rl_strobe1", {31'b0, step_strobe}, 32'd1);
        chk("rl_step1", pattern_out, 32'hFFFF_FFFD);
        chk("rl_wrap1", {31'b0, wrap}, 32'd0);
        cyc(1);
        chk("rl_strobe_drop", {31'b0, step_strobe}, 32'd0);
        cyc(3);
        chk("rl_strobe2", {31'b0, step_strobe}, 32'd1);
        chk("rl_step2", pattern_out, 32'hFFFF_FFFB);
        wrap_seen  = 1'b0;
        strobe_all = 1'b1;
        for (int k = 3; k <= 31; k++) begin
            cyc(4);
            wrap_seen  = wrap_seen | wrap;
            strobe_all = strobe_all & step_strobe;
        end
        chk("rl_strobe_3_31", {31'b0, strobe_all}, 32'd1);
        chk("rl_wrap_3_31", {31'b0, wrap_seen}, 32'd0);
        chk("rl_step31", pattern_out, 32'h7FFF_FFFF);
        cyc(4);
        chk("rl_step32", pattern_out, 32'hFFFF_FFFE);
        chk("rl_wrap32", {31'b0, wrap}, 32'd1);
        cyc(1);
        chk("rl_wrap_drop", {31'b0, wrap}, 32'd0);

        // ---- rot-right, div=0: strobe every cycle, wrap on step 32
        div  = 24'd0;
        mode = 2'b01;
        cyc(2);
        chk("rr_step1", pattern_out, 32'h7FFF_FFFF);
        chk("rr_strobe1", {31'b0, step_strobe}, 32'd1);
        cyc(1);
        chk("rr_step2", pattern_out, 32'hBFFF_FFFF);
        wrap_seen  = 1'b0;
        strobe_all = 1'b1;
        for (int k = 3; k <= 31; k++) begin
            cyc(1);
            wrap_seen  = wrap_seen | wrap;
            strobe_all = strobe_all & step_strobe;
        end
        chk("rr_strobe_every_cycle", {31'b0, strobe_all}, 32'd1);
        chk("rr_wrap_3_31", {31'b0, wrap_seen}, 32'd0);
        chk("rr_step31", pattern_out, 32'hFFFF_FFFD);
        cyc(1);
        chk("rr_step32", pattern_out, 32'hFFFF_FFFE);
        chk("rr_wrap32", {31'b0, wrap}, 32'd1);

        // ---- load on an edge where tick_q=1 (div=0 keeps it high)
        load         = 1'b1;
        load_pattern = 32'hA5A5_0000;
        div          = 24'd3;
        mode         = 2'b00;
        cyc(1);
        load = 1'b0;
        chk("ld_pattern", pattern_out, 32'hA5A5_0000);
        chk("ld_no_strobe", {31'b0, step_strobe}, 32'd0);
        chk("ld_no_wrap", {31'b0, wrap}, 32'd0);
        cyc(4);
        chk("ld_no_strobe_div1", {31'b0, step_strobe}, 32'd0);
        chk("ld_hold_until_step", pattern_out, 32'hA5A5_0000);
        cyc(1);
        chk("ld_strobe_div2", {31'b0, step_strobe}, 32'd1);
        chk("ld_first_step", pattern_out, 32'h4B4A_0001);

        // ---- div=20, shrink to 4 at cnt=10
        div         = 24'd20;
        strobe_seen = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cyc(1);
            strobe_seen = strobe_seen | step_strobe;
        end
        chk("div20_no_strobe", {31'b0, strobe_seen}, 32'd0);
        div = 24'd4;
        cyc(1);
        chk("shrink_tick_pending", {31'b0, step_strobe}, 32'd0);
        cyc(1);
        chk("shrink_strobe", {31'b0, step_strobe}, 32'd1);
        chk("shrink_step", pattern_out, 32'h9694_0002);
        cyc(4);
        chk("p5_no_strobe", {31'b0, step_strobe}, 32'd0);
        cyc(1);
        chk("p5_strobe", {31'b0, step_strobe}, 32'd1);
        chk("p5_step", pattern_out, 32'h2D28_0005);

        // ---- enable low for 3 cycles
        enable      = 1'b0;
        strobe_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            strobe_seen = strobe_seen | step_strobe;
        end
        chk("dis_no_strobe", {31'b0, strobe_seen}, 32'd0);
        enable      = 1'b1;
        strobe_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            strobe_seen = strobe_seen | step_strobe;
        end
        chk("reen_no_early_strobe", {31'b0, strobe_seen}, 32'd0);
        cyc(1);
        chk("reen_strobe", {31'b0, step_strobe}, 32'd1);
        chk("reen_step", pattern_out, 32'h5A50_000A);

        // ---- hold mode
        mode = 2'b11;
        cyc(5);
        chk("hold_strobe1", {31'b0, step_strobe}, 32'd1);
        chk("hold_pattern1", pattern_out, 32'h5A50_000A);
        chk("hold_wrap1", {31'b0, wrap}, 32'd0);
        cyc(5);
        chk("hold_strobe2", {31'b0, step_strobe}, 32'd1);
        chk("hold_pattern2", pattern_out, 32'h5A50_000A);

        // ---- async reset between edges
        #2;
        rstn = 1'b0;
        #1;
        chk("async_pattern", pattern_out, 32'hFFFF_FFFE);
        chk("async_strobe", {31'b0, step_strobe}, 32'd0);
        chk("async_wrap", {31'b0, wrap}, 32'd0);

        // ---- 8-bit ping-pong, div=1
        enable   = 1'b0;
        enable_b = 1'b1;
        cyc(1);
        rstn = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 0) cyc(3);
            else        cyc(2);
            chk($sformatf("pp_step%0d", k + 1), {24'b0, pattern_b}, {24'b0, pp_exp[k]});
            chk($sformatf("pp_wrap%0d", k + 1), {31'b0, wrap_b}, (k == 13) ? 32'd1 : 32'd0);
            chk($sformatf("pp_strobe%0d", k + 1), {31'b0, strobe_b}, 32'd1);
        end
        cyc(1);
        chk("pp_strobe_gap", {31'b0, strobe_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
